// File: rtl/sram_like_responder_pkg.sv
// Shared types and helpers for the SRAM-like bus responder.
package sram_like_responder_pkg;

  typedef enum logic [1:0] {
    SRAM_SIZE_B = 2'd0,
    SRAM_SIZE_H = 2'd1,
    SRAM_SIZE_W = 2'd2
  } sram_size_e;

  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_LANES  = 4;

  // Countdown width; a LATENCY of 1 still needs a 1-bit field.
  function automatic int rsp_cnt_w(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

  function automatic int sram_rsp_w(input int latency);
    return 1 + SRAM_DATA_W + rsp_cnt_w(latency);
  endfunction

endpackage

// File: rtl/sram_like_responder_resp_fifo.sv
// In-order response FIFO; each entry counts down to its earliest delivery cycle.
module sram_like_responder_resp_fifo
  import sram_like_responder_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_push_wr,
  input  logic [SRAM_DATA_W-1:0] i_late_data,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic                   o_head_ready,
  output logic                   o_head_is_wr,
  output logic [SRAM_DATA_W-1:0] o_head_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = rsp_cnt_w(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);
  localparam logic [PTR_W:0]   COUNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [DEPTH-1:0]       r_valid;
  logic [DEPTH-1:0]       r_is_wr;
  logic [CNT_W-1:0]       r_cnt  [DEPTH];
  logic [SRAM_DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W:0]         r_count;
  logic                   r_late_pend;
  logic [PTR_W-1:0]       r_late_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= '0;
      r_is_wr     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_late_pend <= 1'b0;
      r_late_idx  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_push && (r_wr_ptr == PTR_W'(i))) begin
          r_valid[i] <= 1'b1;
          r_is_wr[i] <= i_push_wr;
          r_cnt[i]   <= CNT_LOAD;
        end else begin
          if (i_pop && (r_rd_ptr == PTR_W'(i))) begin
            r_valid[i] <= 1'b0;
          end
          if (r_valid[i] && (r_cnt[i] != '0)) begin
            r_cnt[i] <= r_cnt[i] - CNT_W'(1);
          end
        end
      end

      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase

      // Read data arrives from the memory's output register one cycle after the push.
      r_late_pend <= i_push & ~i_push_wr;
      if (i_push) begin
        r_late_idx <= r_wr_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_late_pend) begin
      r_data[r_late_idx] <= i_late_data;
    end
  end

  assign o_full       = (r_count == COUNT_MAX);
  assign o_head_ready = r_valid[r_rd_ptr] && (r_cnt[r_rd_ptr] == '0);
  assign o_head_is_wr = r_is_wr[r_rd_ptr];
  // With LATENCY=1 the head can be delivered in the same cycle its data lands.
  assign o_head_rdata = (r_late_pend && (r_late_idx == r_rd_ptr)) ? i_late_data
                                                                  : r_data[r_rd_ptr];

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like bus target: lane-masked word memory with in-order, latency-delayed responses.
module sram_like_responder
  import sram_like_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int MAX_OUTST  = 4,
  parameter int LATENCY    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   wr,
  input  logic [1:0]             size,
  input  logic [3:0]             wstrb,
  input  logic [31:0]            addr,
  input  logic [SRAM_DATA_W-1:0] wdata,
  output logic                   addr_ok,
  output logic                   data_ok,
  output logic [SRAM_DATA_W-1:0] rdata,
  input  logic                   addr_stall
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic                   w_full;
  logic                   w_accept;
  logic                   w_head_ready;
  logic                   w_head_is_wr;
  logic [SRAM_DATA_W-1:0] w_head_rdata;
  logic [SRAM_DATA_W-1:0] w_rd_word;
  logic [DEPTH_LOG2-1:0]  w_idx;
  logic                   w_unused;

  assign w_idx    = addr[DEPTH_LOG2+1:2];
  assign addr_ok  = ~reset & ~w_full & ~addr_stall;
  assign w_accept = req & addr_ok;
  // Transfer size is informational; write lanes come from wstrb alone.
  assign w_unused = ^{size, addr[31:DEPTH_LOG2+2], addr[1:0]};

  for (genvar gi = 0; gi < SRAM_LANES; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd_byte;

    always_ff @(posedge clk) begin
      if (w_accept && wr && wstrb[gi]) begin
        r_mem[w_idx] <= wdata[8*gi +: 8];
      end
      if (w_accept && !wr) begin
        r_rd_byte <= r_mem[w_idx];
      end
    end

    assign w_rd_word[8*gi +: 8] = r_rd_byte;
  end

  sram_like_responder_resp_fifo #(
    .DEPTH   (MAX_OUTST),
    .LATENCY (LATENCY)
  ) u_resp_fifo (
    .clk          (clk),
    .rst          (reset),
    .i_push       (w_accept),
    .i_push_wr    (wr),
    .i_late_data  (w_rd_word),
    .i_pop        (w_head_ready),
    .o_full       (w_full),
    .o_head_ready (w_head_ready),
    .o_head_is_wr (w_head_is_wr),
    .o_head_rdata (w_head_rdata)
  );

  assign data_ok = w_head_ready;
  assign rdata   = (w_head_ready && !w_head_is_wr) ? w_head_rdata : '0;

endmodule
